trim_sum_frame: RTL and testbench

Parametrised frame-based trimmed-sum engine. Accepts a stream of unsigned samples over a valid/ready handshake and groups them into fixed-length frames of FRAME_LEN samples. For each frame it outputs the sum of all samples minus one maximum and one minimum, together with the frame's max and min. It sits after the sample capture stage and feeds the statistics/reporting path, with output backpressure support.

---
 rtl/trim_sum_frame_if.sv | 42 ++++
 rtl/trim_sum_frame.sv | 97 +++++++++
 tb/tb_trim_sum_frame.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/trim_sum_frame_if.sv
// Sample-in / result-out bundle for the trimmed-sum frame engine.
// master drives samples and consumes results; slave is the engine.
interface trim_sum_frame_if #(
  parameter int DW        = 8,
  parameter int FRAME_LEN = 16
);
  localparam int SW = DW + $clog2(FRAME_LEN);

  logic [DW-1:0] in_data;
  logic          in_vld;
  logic          in_rdy;
  logic          flush;
  logic [SW-1:0] out_sum;
  logic [DW-1:0] out_max;
  logic [DW-1:0] out_min;
  logic          out_vld;
  logic          out_rdy;

  modport master (
    output in_data,
    output in_vld,
    input  in_rdy,
    output flush,
    input  out_sum,
    input  out_max,
    input  out_min,
    input  out_vld,
    output out_rdy
  );

  modport slave (
    input  in_data,
    input  in_vld,
    output in_rdy,
    input  flush,
    output out_sum,
    output out_max,
    output out_min,
    output out_vld,
    input  out_rdy
  );
endinterface

// File: rtl/trim_sum_frame.sv
// Frame trimmed-sum engine: sums FRAME_LEN samples and removes one
// max and one min; result held in an output register until consumed.
module trim_sum_frame #(
  parameter int DW        = 8,
  parameter int FRAME_LEN = 16
) (
  input logic             clk,
  input logic             rst_n,
  trim_sum_frame_if.slave bus
);
  localparam int SW = DW + $clog2(FRAME_LEN);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0] cnt;
  logic [SW-1:0] acc;
  logic [DW-1:0] mx;
  logic [DW-1:0] mn;

  logic [SW-1:0] res_sum;
  logic [DW-1:0] res_max;
  logic [DW-1:0] res_min;
  logic          res_vld;

  logic          first;
  logic          last;
  logic          take;
  logic          done;
  logic          drain;
  logic [SW-1:0] nxt_acc;
  logic [DW-1:0] nxt_mx;
  logic [DW-1:0] nxt_mn;
  logic [SW-1:0] trim;

  // Only the completing sample stalls behind an unconsumed result.
  assign first = (cnt == '0);
  assign last  = (cnt == LAST);
  assign drain = res_vld && bus.out_rdy;
  assign bus.in_rdy = !bus.flush && !(last && res_vld && !bus.out_rdy);
  assign take  = bus.in_vld && bus.in_rdy;
  assign done  = take && last;

  // Running sum/extremes including the sample on the bus this cycle.
  always_comb begin
    nxt_acc = SW'(bus.in_data);
    nxt_mx  = bus.in_data;
    nxt_mn  = bus.in_data;
    if (!first) begin
      nxt_acc = acc + SW'(bus.in_data);
      if (mx > bus.in_data) nxt_mx = mx;
      if (mn < bus.in_data) nxt_mn = mn;
    end
    trim = nxt_acc - SW'(nxt_mx) - SW'(nxt_mn);
  end

  // Frame accumulator; flush and frame end both restart from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      mx  <= '0;
      mn  <= '0;
    end else if (bus.flush || done) begin
      cnt <= '0;
      acc <= '0;
      mx  <= '0;
      mn  <= '0;
    end else if (take) begin
      cnt <= cnt + CW'(1);
      acc <= nxt_acc;
      mx  <= nxt_mx;
      mn  <= nxt_mn;
    end
  end

  // Result register: reload on completion, else drop valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum <= '0;
      res_max <= '0;
      res_min <= '0;
      res_vld <= 1'b0;
    end else if (done) begin
      res_sum <= trim;
      res_max <= nxt_mx;
      res_min <= nxt_mn;
      res_vld <= 1'b1;
    end else if (drain) begin
      res_vld <= 1'b0;
    end
  end

  assign bus.out_sum = res_sum;
  assign bus.out_max = res_max;
  assign bus.out_min = res_min;
  assign bus.out_vld = res_vld;
endmodule

// File: tb/tb_trim_sum_frame.sv
// Directed bench for trim_sum_frame: FRAME_LEN=4 scenarios plus a
// FRAME_LEN=256 all-ones throughput/width run.
module tb_trim_sum_frame;
  logic clk;
  logic rst_n;
  int   nchk;
  int   nfail;

  trim_sum_frame_if #(.DW(8), .FRAME_LEN(4))   if4 ();
  trim_sum_frame_if #(.DW(8), .FRAME_LEN(256)) if256 ();

  trim_sum_frame #(.DW(8), .FRAME_LEN(4)) u4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if4.slave)
  );

  trim_sum_frame #(.DW(8), .FRAME_LEN(256)) u256 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if256.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [7:0] d);
    int n;
    @(negedge clk);
    if4.in_vld  = 1'b1;
    if4.in_data = d;
    n = 0;
    #1;
    while (!if4.in_rdy && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    nchk++;
    if (!if4.in_rdy) begin
      nfail++;
      $display("FAIL push_timeout data=%0d in_rdy=%0b want 1", d, if4.in_rdy);
    end
    @(posedge clk);
    #1;
    if4.in_vld = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic v,
                         input int s, input int mxv, input int mnv);
    nchk++;
    if (if4.out_vld !== v || if4.out_sum !== 10'(s) ||
        if4.out_max !== 8'(mxv) || if4.out_min !== 8'(mnv)) begin
      nfail++;
      $display("FAIL %s got vld=%0b sum=%0d max=%0d min=%0d want vld=%0b sum=%0d max=%0d min=%0d",
               nm, if4.out_vld, if4.out_sum, if4.out_max, if4.out_min,
               v, s, mxv, mnv);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if4.in_vld = 0; if4.in_data = 0; if4.flush = 0; if4.out_rdy = 1;
    if256.in_vld = 0; if256.in_data = 0; if256.flush = 0; if256.out_rdy = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("reset_out", 1'b0, 0, 0, 0);
    nchk++;
    if (if4.in_rdy !== 1'b1) begin
      nfail++;
      $display("FAIL reset_in_rdy got %0b want 1", if4.in_rdy);
    end
  endtask

  task automatic test_basic;
    if4.out_rdy = 1'b1;
    push(10); push(20); push(30); push(40);
    chk_out("basic", 1'b1, 50, 40, 10);
    @(posedge clk); #1;
    chk_out("basic_consumed", 1'b0, 50, 40, 10);
  endtask

  task automatic test_ties;
    push(5); push(5); push(5); push(5);
    chk_out("ties_same", 1'b1, 10, 5, 5);
    push(0); push(255); push(0); push(255);
    chk_out("ties_extremes", 1'b1, 255, 255, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    push(1); push(2); push(3); push(4);
    chk_out("b2b_first", 1'b1, 5, 4, 1);
    push(5); push(6); push(7); push(8);
    chk_out("b2b_second", 1'b1, 13, 8, 5);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    if4.out_rdy = 1'b0;
    push(1); push(2); push(3); push(4);
    chk_out("bp_first", 1'b1, 5, 4, 1);
    push(7); push(8); push(9);
    chk_out("bp_held", 1'b1, 5, 4, 1);
    @(negedge clk);
    if4.in_vld = 1'b1;
    if4.in_data = 8'd10;
    #1;
    nchk++;
    if (if4.in_rdy !== 1'b0) begin
      nfail++;
      $display("FAIL bp_stall in_rdy got %0b want 0", if4.in_rdy);
    end
    repeat (2) @(posedge clk);
    #1;
    chk_out("bp_stable", 1'b1, 5, 4, 1);
    @(negedge clk);
    if4.out_rdy = 1'b1;
    #1;
    nchk++;
    if (if4.in_rdy !== 1'b1) begin
      nfail++;
      $display("FAIL bp_release in_rdy got %0b want 1", if4.in_rdy);
    end
    @(posedge clk); #1;
    if4.in_vld = 1'b0;
    chk_out("bp_second", 1'b1, 17, 10, 7);
    @(posedge clk); #1;
    chk_out("bp_drained", 1'b0, 17, 10, 7);
  endtask

  task automatic test_flush;
    push(100); push(200);
    @(negedge clk);
    if4.flush = 1'b1;
    #1;
    nchk++;
    if (if4.in_rdy !== 1'b0) begin
      nfail++;
      $display("FAIL flush_in_rdy got %0b want 0", if4.in_rdy);
    end
    @(negedge clk);
    if4.flush = 1'b0;
    push(1); push(2); push(3); push(4);
    chk_out("flush_partial", 1'b1, 5, 4, 1);
    @(posedge clk); #1;
    if4.out_rdy = 1'b0;
    push(2); push(4); push(6); push(8);
    @(negedge clk);
    if4.flush = 1'b1;
    repeat (2) @(negedge clk);
    if4.flush = 1'b0;
    #1;
    chk_out("flush_pending", 1'b1, 10, 8, 2);
    @(negedge clk);
    if4.out_rdy = 1'b1;
    @(posedge clk); #1;
    chk_out("flush_delivered", 1'b0, 10, 8, 2);
  endtask

  task automatic test_reset_mid;
    if4.out_rdy = 1'b0;
    push(3); push(6); push(9); push(12);
    chk_out("rst_pending", 1'b1, 15, 12, 3);
    push(50); push(60);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    if4.out_rdy = 1'b1;
    push(1); push(1); push(2); push(9);
    chk_out("rst_fresh", 1'b1, 3, 9, 1);
    @(posedge clk); #1;
  endtask

  task automatic test_wide;
    int hits;
    int first_at;
    int second_at;
    int sum_at_first;
    hits = 0; first_at = -1; second_at = -1; sum_at_first = 0;
    @(negedge clk);
    if256.out_rdy = 1'b1;
    if256.in_data = 8'd255;
    if256.in_vld  = 1'b1;
    for (int i = 0; i < 520; i++) begin
      @(posedge clk); #1;
      if (if256.out_vld) begin
        hits++;
        if (first_at < 0) begin
          first_at = i;
          sum_at_first = int'(if256.out_sum);
        end else if (second_at < 0) begin
          second_at = i;
        end
      end
      if (i == 511) if256.in_vld = 1'b0;
    end
    nchk++;
    if (hits != 2 || first_at != 255 || second_at != 511) begin
      nfail++;
      $display("FAIL wide_timing got hits=%0d at %0d,%0d want 2 at 255,511",
               hits, first_at, second_at);
    end
    nchk++;
    if (sum_at_first != 64770 || if256.out_max !== 8'd255 ||
        if256.out_min !== 8'd255) begin
      nfail++;
      $display("FAIL wide_sum got sum=%0d max=%0d min=%0d want 64770 255 255",
               sum_at_first, if256.out_max, if256.out_min);
    end
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    test_reset;
    test_basic;
    test_ties;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_wide;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule
